// File: rtl/stream_mux_nx1_pkg.sv
// Shared types and helpers for the N-to-1 streaming multiplexer.
//   mux_mode_e : selection mode (fixed select or round-robin)
//   next_idx   : modulo-wrap increment of a channel index
package stream_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/stream_mux_nx1_if.sv
// Handshake/bus bundle for stream_mux_nx1.
//   mode, sel           : selection control (sel used only in fixed mode)
//   in_data/in_valid    : NUM_CH input channels, channel i at [i*WIDTH +: WIDTH]
//   in_ready            : per-channel ready back to the sources
//   out_data/out_ch     : registered output word and its source channel
//   out_valid/out_ready : output handshake
// master = the environment driving the mux, slave = the mux itself.
interface stream_mux_nx1_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SEL_W  = $clog2(NUM_CH)
);
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/stream_mux_nx1_rr_arbiter.sv
// Round-robin arbiter owning the rotating priority pointer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_i       : per-channel requests
//   ptr_i       : index of the channel that transferred this cycle
//   advance_i   : a round-robin transfer happened; move pointer past ptr_i
//   grant_o     : one-hot grant (first request at or after the pointer)
//   grant_idx_o : index of the granted channel
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req_i,
    input  logic [SEL_W-1:0]  ptr_i,
    input  logic              advance_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [SEL_W-1:0]  grant_idx_o
);

    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] cand;
    logic             found;

    // Search rr_ptr, rr_ptr+1, ... wrapping at NUM_CH; first hit wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            cand = SEL_W'((32'(rr_ptr_q) + k >= NUM_CH) ? 32'(rr_ptr_q) + k - NUM_CH
                                                         : 32'(rr_ptr_q) + k);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                grant_o[cand]  = 1'b1;
                grant_idx_o    = cand;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance_i) begin
            rr_ptr_d = SEL_W'(next_idx(32'(ptr_i), NUM_CH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/stream_mux_nx1.sv
// Registered N-to-1 streaming multiplexer with fixed-select and round-robin
// modes. One-entry output register: 1-cycle latency, full throughput,
// full backpressure.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : stream_mux_nx1_if slave modport (mode/sel, inputs, output)
module stream_mux_nx1
    import stream_mux_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    stream_mux_nx1_if.slave bus
);

    mux_mode_e         mode_w;
    logic              load_en;
    logic              xfer;
    logic [NUM_CH-1:0] fixed_grant, rr_grant, grant;
    logic [SEL_W-1:0]  rr_idx, grant_idx;
    logic [WIDTH-1:0]  sel_data;

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_ch_q,    out_ch_d;

    assign mode_w  = mux_mode_e'(bus.mode);
    assign load_en = !out_valid_q || bus.out_ready;

    // An out-of-range sel matches no channel, so it simply produces no grant.
    always_comb begin
        fixed_grant = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            fixed_grant[i] = bus.in_valid[i] && (32'(bus.sel) == i);
        end
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (bus.in_valid),
        .ptr_i       (rr_idx),
        .advance_i   (xfer && (mode_w == MODE_RR)),
        .grant_o     (rr_grant),
        .grant_idx_o (rr_idx)
    );

    assign grant     = (mode_w == MODE_RR) ? rr_grant : fixed_grant;
    assign grant_idx = (mode_w == MODE_RR) ? rr_idx   : bus.sel;

    // Grants only exist for valid channels, so any ready implies a transfer.
    assign bus.in_ready = grant & {NUM_CH{load_en}};
    assign xfer         = |bus.in_ready;

    // One-hot AND-OR data select keeps in_data off every ready path.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (load_en) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = sel_data;
                out_ch_d   = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Scoreboard bench for stream_mux_nx1 (NUM_CH=4, WIDTH=8).
module tb_stream_mux_nx1;
    import stream_mux_pkg::*;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned SEL_W  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_mux_nx1_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

    stream_mux_nx1 #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [SEL_W-1:0] ch;
        logic [WIDTH-1:0] data;
    } word_t;

    word_t            exp_q[$];
    word_t            mon_e;
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] chd [NUM_CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [NUM_CH-1:0] valid);
        for (int i = 0; i < NUM_CH; i++) begin
            bus.in_data[i*WIDTH +: WIDTH] = chd[i];
        end
        bus.in_valid = valid;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic [WIDTH-1:0] data);
        word_t w;
        w.ch   = SEL_W'(ch);
        w.data = data;
        exp_q.push_back(w);
    endtask

    // Monitor: an output handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got ch %0d data 0x%0h, expected none",
                         bus.out_ch, bus.out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_out_ch",   32'(bus.out_ch),   32'(mon_e.ch));
                check("sb_out_data", 32'(bus.out_data), 32'(mon_e.data));
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mode      = MODE_FIXED;
        bus.sel       = '0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) chd[i] = '0;

        // Reset state
        #3;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data",  32'(bus.out_data),  0);
        check("rst_out_ch",    32'(bus.out_ch),    0);
        cyc();
        rst_n = 1'b1;

        // 1: async reset mid-stream discards a held word; RR restarts at ch0
        bus.mode = MODE_RR;
        chd[1] = 8'h11;
        drive(4'b0010);
        #1;
        check("t1_in_ready", 32'(bus.in_ready), 32'h2);
        cyc();
        drive(4'b0000);
        #1;
        check("t1_held_valid", 32'(bus.out_valid), 1);
        check("t1_held_data",  32'(bus.out_data),  32'h11);
        rst_n = 1'b0;
        #1;
        check("t1_async_valid", 32'(bus.out_valid), 0);
        check("t1_async_data",  32'(bus.out_data),  0);
        check("t1_async_ch",    32'(bus.out_ch),    0);
        cyc();
        rst_n = 1'b1;
        chd[0] = 8'h0A; chd[1] = 8'h0B; chd[2] = 8'h0C; chd[3] = 8'h0D;
        bus.out_ready = 1'b1;
        drive(4'b1111);
        #1;
        check("t1_first_rr_ready", 32'(bus.in_ready), 32'h1);
        push(0, 8'h0A);
        cyc();
        drive(4'b0000);
        cyc();

        // 2: fixed select ch2; other valid channels get no ready
        bus.mode = MODE_FIXED;
        bus.sel  = 2'd2;
        chd[0] = 8'h5A; chd[1] = 8'h5B; chd[2] = 8'hA5; chd[3] = 8'h5D;
        drive(4'b1111);
        #1;
        check("t2_in_ready", 32'(bus.in_ready), 32'h4);
        push(2, 8'hA5);
        cyc();
        drive(4'b0000);
        cyc();

        // Re-reset to put the RR pointer back at 0
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;

        // 3: RR across all channels at full rate
        bus.mode = MODE_RR;
        chd[0] = 8'h10; chd[1] = 8'h20; chd[2] = 8'h30; chd[3] = 8'h40;
        drive(4'b1111);
        push(0, 8'h10); push(1, 8'h20); push(2, 8'h30);
        push(3, 8'h40); push(0, 8'h10); push(1, 8'h20);
        repeat (6) cyc();
        drive(4'b0000);
        cyc();

        // 4: backpressure holding 0x20, then same-cycle drain and refill
        bus.out_ready = 1'b0;
        drive(4'b0010);
        push(1, 8'h20);
        cyc();
        drive(4'b1111);
        repeat (3) begin
            #1;
            check("t4_stall_valid", 32'(bus.out_valid), 1);
            check("t4_stall_data",  32'(bus.out_data),  32'h20);
            check("t4_stall_ch",    32'(bus.out_ch),    1);
            check("t4_stall_ready", 32'(bus.in_ready),  0);
            cyc();
        end
        bus.out_ready = 1'b1;
        #1;
        check("t4_refill_ready", 32'(bus.in_ready), 32'h4);
        push(2, 8'h30);
        cyc();
        drive(4'b0000);
        cyc();

        // 5: move pointer to 2, then ch3/ch1 only: ch3 then wrap to ch1
        chd[1] = 8'h61;
        drive(4'b0010);
        push(1, 8'h61);
        cyc();
        drive(4'b0000);
        cyc();
        chd[1] = 8'h71; chd[3] = 8'h73;
        drive(4'b1010);
        #1;
        check("t5_skip_ready", 32'(bus.in_ready), 32'h8);
        push(3, 8'h73); push(1, 8'h71);
        repeat (2) cyc();
        drive(4'b0000);
        cyc();
        chd[2] = 8'h82;
        drive(4'b1111);
        #1;
        check("t5_ptr_at_2", 32'(bus.in_ready), 32'h4);
        push(2, 8'h82);
        cyc();
        drive(4'b0000);
        cyc();

        // 6: pointer to 1, two fixed sel=3 words, RR resumes at ch1
        chd[0] = 8'h90;
        drive(4'b0001);
        push(0, 8'h90);
        cyc();
        drive(4'b0000);
        cyc();
        bus.mode = MODE_FIXED;
        bus.sel  = 2'd3;
        chd[1] = 8'h91; chd[2] = 8'h92; chd[3] = 8'h93;
        drive(4'b1111);
        #1;
        check("t6_fixed_ready", 32'(bus.in_ready), 32'h8);
        push(3, 8'h93);
        cyc();
        chd[3] = 8'h94;
        drive(4'b1111);
        push(3, 8'h94);
        cyc();
        bus.mode = MODE_RR;
        #1;
        check("t6_rr_resume_ready", 32'(bus.in_ready), 32'h2);
        push(1, 8'h91);
        cyc();
        drive(4'b0000);
        repeat (3) cyc();

        check("sb_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
